// File: rtl/bcd_serial_add_ctrl.sv
// bcd_serial_add_ctrl
//   Adds two packed-BCD operands one digit per clock, least-significant digit
//   first. A single BCD digit adder is reused for every digit position. The
//   digit carry passes from one position to the next through a register.
//
//   Optional feature macro: BCD_SERIAL_ERR_EN
//     Defined     : nibbles above 9 are flagged on err, which is presented
//                   together with the result.
//     Not defined : err is tied to 0.
//
// Ports
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   start    in   request; sampled only while idle
//   a, b     in   packed BCD operands, digit 0 = [3:0]
//   c_in     in   carry into digit 0
//   busy     out  high while digits are being processed
//   done     out  one-cycle pulse; sum/c_out/err are valid
//   sum      out  packed BCD result, held between operations
//   c_out    out  carry out of the most-significant digit
//   err      out  invalid-digit flag

module bcd_adder_digit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);
  logic [4:0] bin;

  always_comb begin
    bin = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, c_i};
    if (bin > 5'd9) begin
      s_o = bin[3:0] + 4'd6;
      c_o = 1'b1;
    end else begin
      s_o = bin[3:0];
      c_o = 1'b0;
    end
  end
endmodule

module bcd_serial_add_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                c_in,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] sum,
  output logic                c_out,
  output logic                err
);
  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_sr_q, a_sr_d;
  logic [W-1:0]    b_sr_q, b_sr_d;
  logic [W-1:0]    sr_q, sr_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            c_out_q, c_out_d;

  logic [3:0]      dig_s;
  logic            dig_c;
  logic [W+3:0]    sr_cat;
  logic            last_digit;

  bcd_adder_digit u_digit (
    .a_i (a_sr_q[3:0]),
    .b_i (b_sr_q[3:0]),
    .c_i (carry_q),
    .s_o (dig_s),
    .c_o (dig_c)
  );

  // New digit enters at the MS end. After DIGITS shifts, digit 0 sits in [3:0].
  assign sr_cat     = {dig_s, sr_q};
  assign last_digit = (idx_q == IW'(DIGITS - 1));

`ifdef BCD_SERIAL_ERR_EN
  logic flag_q, flag_d;
  logic err_q, err_d;
  logic bad_nibble;

  assign bad_nibble = (a_sr_q[3:0] > 4'd9) || (b_sr_q[3:0] > 4'd9);
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    sr_d    = sr_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
`ifdef BCD_SERIAL_ERR_EN
    flag_d  = flag_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ADD;
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = c_in;
          idx_d   = '0;
`ifdef BCD_SERIAL_ERR_EN
          flag_d  = 1'b0;
          err_d   = 1'b0;
`endif
        end
      end
      S_ADD: begin
        a_sr_d  = a_sr_q >> 4;
        b_sr_d  = b_sr_q >> 4;
        sr_d    = sr_cat[W+3:4];
        carry_d = dig_c;
        idx_d   = idx_q + 1'b1;
`ifdef BCD_SERIAL_ERR_EN
        flag_d  = flag_q | bad_nibble;
`endif
        // The result registers load on the edge that enters DONE, so that
        // sum/c_out/err are already valid in the cycle where done is high.
        if (last_digit) begin
          state_d = S_DONE;
          sum_d   = sr_cat[W+3:4];
          c_out_d = dig_c;
`ifdef BCD_SERIAL_ERR_EN
          err_d   = flag_q | bad_nibble;
`endif
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      sr_q    <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      sr_q    <= sr_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
    end
  end

`ifdef BCD_SERIAL_ERR_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flag_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      flag_q <= flag_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign busy  = (state_q == S_ADD);
  assign done  = (state_q == S_DONE);
  assign sum   = sum_q;
  assign c_out = c_out_q;
endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// tb_bcd_serial_add_ctrl
//   Directed bench for bcd_serial_add_ctrl. The main instance uses DIGITS=4.
//   A second instance uses DIGITS=1 to cover the single-digit boundary case.
//   Expected sums are worked out by hand.

module tb_bcd_serial_add_ctrl;
  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [W-1:0] a, b, sum;
  logic         c_in, busy, done, c_out, err;

  logic         start1, c_in1, busy1, done1, c_out1, err1;
  logic [3:0]   a1, b1, sum1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_cnt  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt++;

  bcd_serial_add_ctrl #(.DIGITS(DIGITS)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .a(a), .b(b), .c_in(c_in),
    .busy(busy), .done(done), .sum(sum), .c_out(c_out), .err(err)
  );

  bcd_serial_add_ctrl #(.DIGITS(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .a(a1), .b(b1), .c_in(c_in1),
    .busy(busy1), .done(done1), .sum(sum1), .c_out(c_out1), .err(err1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Count negedges from cycle T+1, which is cyc=1, until done is seen.
  // The wait is bounded.
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // One full operation. The operand inputs are scrambled after accept.
  task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci,
                        input logic chk_sum, input logic [W-1:0] exp_s,
                        input logic exp_c, input logic exp_e);
    int cyc;
    @(negedge clk);
    a = ai; b = bi; c_in = ci; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_accept", busy, 1);
    a = 16'h4321; b = 16'h8765; c_in = ~ci;
    wait_done(cyc);
    check("latency", cyc, DIGITS + 1);
    if (chk_sum) begin
      check("sum", sum, exp_s);
      check("c_out", c_out, exp_c);
    end
    check("err", err, exp_e);
    check("busy_in_done", busy, 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
  endtask

  initial begin
    int cyc, d1, d2;
    logic seen;
    reset_n = 1'b0; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; c_in1 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_c_out", c_out, 0);
    check("rst_err", err, 0);
    reset_n = 1'b1;

    run_op(16'h1234, 16'h5678, 1'b0, 1'b1, 16'h6912, 1'b0, 1'b0);
    run_op(16'h9999, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    run_op(16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b0);
    run_op(16'h9999, 16'h9999, 1'b1, 1'b1, 16'h9999, 1'b1, 1'b0);
    run_op(16'h0500, 16'h0500, 1'b0, 1'b1, 16'h1000, 1'b0, 1'b0);
    run_op(16'h5000, 16'h5000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);

    // start is held high. Each accept uses the operands present at its edge.
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; c_in = 1'b0; start = 1'b1;
    @(negedge clk);
    check("hold_busy1", busy, 1);
    a = 16'h3333; b = 16'h4444;
    wait_done(cyc);
    d1 = cyc_cnt;
    check("hold_latency1", cyc, DIGITS + 1);
    check("hold_sum1", sum, 16'h3333);
    @(negedge clk);
    check("hold_idle_busy", busy, 0);
    check("hold_idle_done", done, 0);
    @(negedge clk);
    check("hold_busy2", busy, 1);
    a = 16'h0101; b = 16'h0202; start = 1'b0;
    wait_done(cyc);
    d2 = cyc_cnt;
    check("hold_latency2", cyc, DIGITS + 1);
    check("hold_sum2", sum, 16'h7777);
    check("hold_spacing", d2 - d1, DIGITS + 2);
    @(negedge clk);

    // A reset in the middle of an operation aborts it.
    @(negedge clk);
    a = 16'h1234; b = 16'h1111; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_sum", sum, 0);
    check("abort_c_out", c_out, 0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    check("abort_no_done", seen, 0);
    run_op(16'h1234, 16'h5678, 1'b0, 1'b1, 16'h6912, 1'b0, 1'b0);

`ifdef BCD_SERIAL_ERR_EN
    run_op(16'h00A0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    run_op(16'h0010, 16'h0000, 1'b0, 1'b1, 16'h0010, 1'b0, 1'b0);
`endif

    // DIGITS=1: a single ADD cycle, with done at T+2.
    @(negedge clk);
    a1 = 4'h7; b1 = 4'h5; c_in1 = 1'b0; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; a1 = 4'h0; b1 = 4'h0;
    check("d1_busy", busy1, 1);
    check("d1_no_done_yet", done1, 0);
    @(negedge clk);
    check("d1_done", done1, 1);
    check("d1_sum", sum1, 4'h2);
    check("d1_c_out", c_out1, 1);
    @(negedge clk);
    check("d1_done_pulse", done1, 0);
    a1 = 4'h4; b1 = 4'h3; c_in1 = 1'b1; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    @(negedge clk);
    check("d1_done2", done1, 1);
    check("d1_sum2", sum1, 4'h8);
    check("d1_c_out2", c_out1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
